// File: rtl/tdl_chk_pkg.sv
// Shared types and widths for the odata sequence checker.
package tdl_chk_pkg;

    localparam int CHK_CNT_W = 16;

    typedef enum logic [2:0] {
        CHK_IDLE  = 3'd0,
        CHK_SYNC  = 3'd1,
        CHK_CHECK = 3'd2,
        CHK_PASS  = 3'd3,
        CHK_FAIL  = 3'd4
    } chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear, saturating increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/odata_seq_checker.sv
// Locks onto an incrementing data stream and reports sticky pass/fail,
// with saturating match/error counters and an optional no-data timeout.
module odata_seq_checker
    import tdl_chk_pkg::*;
#(
    parameter int DW       = 8,
    parameter int PASS_CNT = 16,
    parameter int MAX_ERR  = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 sys_clock,
    input  logic                 sys_rst,
    input  logic                 enable,
    input  logic [DW-1:0]        idata,
    input  logic                 ivalid,
    output logic                 unit_pass,
    output logic                 unit_fail,
    output logic                 done,
    output logic [CHK_CNT_W-1:0] match_cnt,
    output logic [CHK_CNT_W-1:0] err_cnt,
    output logic [DW-1:0]        expect_o
);

    localparam int TMO_W = 32;
    localparam logic [31:0]   PASS_TGT = PASS_CNT;
    localparam logic [31:0]   ERR_TGT  = MAX_ERR;
    localparam logic [31:0]   TMO_TGT  = TIMEOUT;
    localparam logic          TMO_ON   = (TIMEOUT != 0);
    localparam logic [DW-1:0] DATA_ONE = {{(DW-1){1'b0}}, 1'b1};

    chk_state_e state_q, state_d;
    logic [DW-1:0] expect_q, expect_d;
    logic pass_q, pass_d;
    logic fail_q, fail_d;
    logic done_q;

    logic match_inc_s, match_clr_s, match_sat_s;
    logic err_inc_s, err_clr_s, err_sat_s;
    logic tmo_inc_s, tmo_clr_s, tmo_sat_s;
    logic [CHK_CNT_W-1:0] match_cnt_s, err_cnt_s;
    logic [TMO_W-1:0] tmo_cnt_s;
    logic [31:0] match_nxt_s, err_nxt_s, tmo_nxt_s;
    logic match_hit_s, err_hit_s, tmo_hit_s;

    sat_counter #(.W(CHK_CNT_W)) u_match_cnt (
        .clk(sys_clock), .rst(sys_rst), .clr(match_clr_s), .inc(match_inc_s),
        .cnt(match_cnt_s), .sat(match_sat_s)
    );

    sat_counter #(.W(CHK_CNT_W)) u_err_cnt (
        .clk(sys_clock), .rst(sys_rst), .clr(err_clr_s), .inc(err_inc_s),
        .cnt(err_cnt_s), .sat(err_sat_s)
    );

    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk(sys_clock), .rst(sys_rst), .clr(tmo_clr_s), .inc(tmo_inc_s),
        .cnt(tmo_cnt_s), .sat(tmo_sat_s)
    );

    // thresholds are judged on the value each counter will hold after this edge
    assign match_nxt_s = {16'h0000, match_cnt_s} + 32'd1;
    assign err_nxt_s   = {16'h0000, err_cnt_s} + 32'd1;
    assign tmo_nxt_s   = tmo_cnt_s + 32'd1;
    assign match_hit_s = match_sat_s || (match_nxt_s >= PASS_TGT);
    assign err_hit_s   = err_sat_s || (err_nxt_s >= ERR_TGT);
    assign tmo_hit_s   = tmo_sat_s || (tmo_nxt_s >= TMO_TGT);

    // next-state, expected value, flags and counter controls
    always_comb begin
        state_d     = state_q;
        expect_d    = expect_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        match_inc_s = 1'b0;
        match_clr_s = 1'b0;
        err_inc_s   = 1'b0;
        err_clr_s   = 1'b0;
        tmo_inc_s   = 1'b0;
        tmo_clr_s   = 1'b0;
        case (state_q)
            CHK_IDLE: begin
                pass_d = 1'b0;
                fail_d = 1'b0;
                if (enable) begin
                    state_d     = CHK_SYNC;
                    match_clr_s = 1'b1;
                    err_clr_s   = 1'b1;
                    tmo_clr_s   = 1'b1;
                end else begin
                    state_d = CHK_IDLE;
                end
            end
            CHK_SYNC, CHK_CHECK: begin
                if (!enable) begin
                    state_d = CHK_IDLE;
                end else if (ivalid) begin
                    tmo_clr_s = 1'b1;
                    expect_d  = idata + DATA_ONE;
                    // the locking sample is a match by definition
                    if ((state_q == CHK_SYNC) || (idata == expect_q)) begin
                        match_inc_s = 1'b1;
                        if (match_hit_s) begin
                            state_d = CHK_PASS;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = CHK_CHECK;
                        end
                    end else begin
                        err_inc_s   = 1'b1;
                        match_clr_s = 1'b1;
                        if (err_hit_s) begin
                            state_d = CHK_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = CHK_CHECK;
                        end
                    end
                end else begin
                    tmo_inc_s = TMO_ON;
                    if (TMO_ON && tmo_hit_s) begin
                        state_d = CHK_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
            end
            CHK_PASS, CHK_FAIL: begin
                if (!enable) begin
                    state_d = CHK_IDLE;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = CHK_IDLE;
                pass_d  = 1'b0;
                fail_d  = 1'b0;
            end
        endcase
    end

    // FSM, expected value and result flags
    always_ff @(posedge sys_clock) begin
        if (sys_rst) begin
            state_q  <= CHK_IDLE;
            expect_q <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            expect_q <= expect_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            done_q   <= pass_d | fail_d;
        end
    end

    assign unit_pass = pass_q;
    assign unit_fail = fail_q;
    assign done      = done_q;
    assign match_cnt = match_cnt_s;
    assign err_cnt   = err_cnt_s;
    assign expect_o  = expect_q;

endmodule
